// File: rtl/classifier_argmax_layer3.sv
// Argmax decision stage behind the layer-3 classifier array.
// Snapshots all membranes on decide, then scans them serially with one comparator.
module classifier_argmax_layer3 #(
    parameter int BIT_WIDTH_MEMBRANE     = 16,
    parameter int BIT_WIDTH_BIG_MEMBRANE = 16,
    parameter int CLASSIFIER_SIZE        = 10,
    localparam int IDX_W = (CLASSIFIER_SIZE > 1) ? $clog2(CLASSIFIER_SIZE) : 1,
    localparam int CMP_W = (BIT_WIDTH_MEMBRANE > BIT_WIDTH_BIG_MEMBRANE)
                           ? BIT_WIDTH_MEMBRANE : BIT_WIDTH_BIG_MEMBRANE
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         decide_i,
    input  logic                                         sel_big_i,
    input  logic [BIT_WIDTH_MEMBRANE*CLASSIFIER_SIZE-1:0]     membrane_i,
    input  logic [BIT_WIDTH_BIG_MEMBRANE*CLASSIFIER_SIZE-1:0] big_membrane_i,
    output logic                                         busy_o,
    output logic                                         result_valid_o,
    input  logic                                         result_ready_i,
    output logic [IDX_W-1:0]                             class_o,
    output logic [CMP_W-1:0]                             max_value_o,
    output logic [CMP_W-1:0]                             margin_o,
    output logic                                         tie_o,
    output logic                                         overrun_o
);

    localparam int W  = BIT_WIDTH_MEMBRANE;
    localparam int WB = BIT_WIDTH_BIG_MEMBRANE;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CLASSIFIER_SIZE - 1);
    localparam logic signed [CMP_W-1:0] MIN_VAL = {1'b1, {(CMP_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t state, state_next;
    logic   accept, finish;

    logic signed [CMP_W-1:0] snap [CLASSIFIER_SIZE];
    logic [IDX_W-1:0]        idx;

    logic signed [CMP_W-1:0] best, second, best_n, second_n, v;
    logic [IDX_W-1:0]        class_cur, class_n;
    logic                    tie_cur, tie_n;
    logic [CMP_W:0]          diff;
    logic [CMP_W-1:0]        margin_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: if (decide_i) begin
                state_next = SCAN;
                accept     = 1'b1;
            end
            SCAN: if (idx == LAST) begin
                state_next = HOLD;
                finish     = 1'b1;
            end
            HOLD: if (result_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single comparator step on the entry addressed by idx
    always_comb begin
        v        = snap[idx];
        best_n   = best;
        second_n = second;
        class_n  = class_cur;
        tie_n    = tie_cur;
        if (idx == '0) begin
            best_n   = v;
            second_n = MIN_VAL;
            class_n  = '0;
            tie_n    = 1'b0;
        end else if (v > best) begin
            second_n = best;
            best_n   = v;
            class_n  = idx;
            tie_n    = 1'b0;
        end else if (v == best) begin
            tie_n    = 1'b1;
            second_n = v;
        end else if (v > second) begin
            second_n = v;
        end
    end

    always_comb begin
        diff = {best_n[CMP_W-1], best_n} - {second_n[CMP_W-1], second_n};
        if (CLASSIFIER_SIZE == 1) margin_n = '0;
        else if (diff[CMP_W])     margin_n = '1;
        else                      margin_n = diff[CMP_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CLASSIFIER_SIZE; k++) snap[k] <= '0;
            idx       <= '0;
            best      <= '0;
            second    <= '0;
            class_cur <= '0;
            tie_cur   <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < CLASSIFIER_SIZE; k++)
                snap[k] <= sel_big_i
                    ? CMP_W'(signed'(big_membrane_i[WB*k +: WB]))
                    : CMP_W'(signed'(membrane_i[W*k +: W]));
            idx <= '0;
        end else if (state == SCAN) begin
            best      <= best_n;
            second    <= second_n;
            class_cur <= class_n;
            tie_cur   <= tie_n;
            idx       <= idx + 1'b1;
        end
    end

    // Result registers hold through IDLE and the next scan
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            class_o     <= '0;
            max_value_o <= '0;
            margin_o    <= '0;
            tie_o       <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            overrun_o <= decide_i && (state != IDLE);
            if (finish) begin
                class_o     <= class_n;
                max_value_o <= best_n;
                margin_o    <= margin_n;
                tie_o       <= (CLASSIFIER_SIZE == 1) ? 1'b0 : tie_n;
            end
        end
    end

    assign busy_o         = (state != IDLE);
    assign result_valid_o = (state == HOLD);

endmodule

// File: tb/tb_classifier_argmax_layer3.sv
// Directed bench for classifier_argmax_layer3 with hand-computed results.
module tb_classifier_argmax_layer3;

    localparam int W = 16;
    localparam int N = 10;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            decide_i = 1'b0;
    logic            sel_big_i = 1'b0;
    logic            result_ready_i = 1'b0;
    logic [W*N-1:0]  membrane_i = '0;
    logic [W*N-1:0]  big_membrane_i = '0;
    logic            busy_o, result_valid_o, tie_o, overrun_o;
    logic [3:0]      class_o;
    logic [15:0]     max_value_o, margin_o;

    int checks = 0;
    int errors = 0;

    classifier_argmax_layer3 dut (
        .clk(clk), .reset_n(reset_n),
        .decide_i(decide_i), .sel_big_i(sel_big_i),
        .membrane_i(membrane_i), .big_membrane_i(big_membrane_i),
        .busy_o(busy_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .class_o(class_o), .max_value_o(max_value_o),
        .margin_o(margin_o), .tie_o(tie_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_set1();
        int vals [N] = '{5, -3, 9, 2, 0, 0, 0, 0, 0, 1};
        for (int k = 0; k < N; k++) membrane_i[W*k +: W] = W'(vals[k]);
    endtask

    task automatic start(input logic big);
        tick();
        sel_big_i = big;
        decide_i  = 1'b1;
        tick();
        decide_i  = 1'b0;
        sel_big_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 1;
        while (!result_valid_o && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_valid"}, result_valid_o, 1'b1);
    endtask

    task automatic expect_res(input string tag, input int cls,
                              input int mx, input int mg, input int t);
        check({tag, "_class"}, class_o, cls);
        check({tag, "_max"}, max_value_o, mx);
        check({tag, "_margin"}, margin_o, mg);
        check({tag, "_tie"}, tie_o, t);
    endtask

    task automatic handshake(input string tag);
        result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        check({tag, "_hs_valid"}, result_valid_o, 1'b0);
        check({tag, "_hs_busy"}, busy_o, 1'b0);
    endtask

    initial begin
        int lat;
        #12;
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", result_valid_o, 1'b0);
        expect_res("rst", 0, 0, 0, 0);
        check("rst_overrun", overrun_o, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        load_set1();
        start(1'b0);
        check("t1_busy", busy_o, 1'b1);
        membrane_i = {N{16'h7FFF}};
        wait_valid("t1", lat);
        check("t1_latency", lat, N + 1);
        expect_res("t1", 2, 9, 4, 1'b0);
        handshake("t1");
        expect_res("t1_keep", 2, 9, 4, 1'b0);

        membrane_i = {N{16'hFFF9}};
        start(1'b0);
        wait_valid("t2", lat);
        check("t2_latency", lat, N + 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t2_hold_valid", result_valid_o, 1'b1);
            expect_res("t2_hold", 0, 16'hFFF9, 0, 1'b1);
        end
        handshake("t2");
        expect_res("t2_keep", 0, 16'hFFF9, 0, 1'b1);

        membrane_i = '0;
        big_membrane_i = {N{16'h8000}};
        big_membrane_i[W*3 +: W] = 16'h7FFF;
        start(1'b1);
        wait_valid("t3", lat);
        check("t3_latency", lat, N + 1);
        expect_res("t3", 3, 16'h7FFF, 16'hFFFF, 1'b0);
        handshake("t3");

        load_set1();
        start(1'b0);
        tick();
        decide_i = 1'b1;
        tick();
        decide_i = 1'b0;
        check("ov_scan_pulse", overrun_o, 1'b1);
        tick();
        check("ov_scan_clear", overrun_o, 1'b0);
        wait_valid("ov", lat);
        expect_res("ov", 2, 9, 4, 1'b0);
        result_ready_i = 1'b1;
        decide_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        decide_i = 1'b0;
        check("ov_hs_pulse", overrun_o, 1'b1);
        check("ov_hs_valid", result_valid_o, 1'b0);
        check("ov_hs_busy", busy_o, 1'b0);
        tick();
        check("ov_hs_clear", overrun_o, 1'b0);
        check("ov_not_started", busy_o, 1'b0);
        expect_res("ov_keep", 2, 9, 4, 1'b0);

        start(1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("rs_busy_before", busy_o, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rs_busy", busy_o, 1'b0);
        check("rs_valid", result_valid_o, 1'b0);
        expect_res("rs", 0, 0, 0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        start(1'b0);
        wait_valid("rs2", lat);
        check("rs2_latency", lat, N + 1);
        expect_res("rs2", 2, 9, 4, 1'b0);
        handshake("rs2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
